// File: rtl/psram_rdata_align_if.sv
// Read-data aligner bus: command, calibration, raw DQ capture and aligned
// read-beat signals. The controller/bench side uses master, the aligner
// uses slave.
interface psram_rdata_align_if #(
    parameter int BIT_WIDTH = 16,
    parameter int CHANNELS  = 2
);
    logic                            rd_start;
    logic [7:0]                      rd_len;
    logic [3:0]                      cfg_lat;
    logic                            cal_start;
    logic [2*BIT_WIDTH-1:0]          cal_pattern;
    logic [CHANNELS*BIT_WIDTH-1:0]   dq_in_hi;
    logic [CHANNELS*BIT_WIDTH-1:0]   dq_in_lo;
    logic [2*CHANNELS*BIT_WIDTH-1:0] rd_data;
    logic                            rd_valid;
    logic                            rd_last;
    logic                            busy;
    logic                            cal_valid;
    logic                            cal_fail;
    logic [4*CHANNELS-1:0]           cal_lat;

    modport master (
        output rd_start, rd_len, cfg_lat, cal_start, cal_pattern,
               dq_in_hi, dq_in_lo,
        input  rd_data, rd_valid, rd_last, busy, cal_valid, cal_fail, cal_lat
    );

    modport slave (
        input  rd_start, rd_len, cfg_lat, cal_start, cal_pattern,
               dq_in_hi, dq_in_lo,
        output rd_data, rd_valid, rd_last, busy, cal_valid, cal_fail, cal_lat
    );
endinterface

// File: rtl/psram_rdata_align.sv
// Multi-channel PSRAM read-data aligner. Each channel captures its beats at
// its own latency into a small de-skew FIFO; beats leave all FIFOs together
// once every channel has one, so the output is aligned to the slowest
// channel. A calibration mode searches each channel's latency by matching a
// known first beat.
module psram_rdata_align #(
    parameter int BIT_WIDTH  = 16,
    parameter int CHANNELS   = 2,
    parameter int MAX_LAT    = 15,
    parameter int SKEW_DEPTH = 4
) (
    input  logic                ram_clk,
    input  logic                rst_n,
    psram_rdata_align_if.slave  bus
);
    localparam int DW = 2 * BIT_WIDTH;
    localparam int PW = (SKEW_DEPTH > 1) ? $clog2(SKEW_DEPTH) : 1;
    localparam int CW = $clog2(SKEW_DEPTH + 1);
    localparam logic [3:0]    LAT_TOP  = 4'(MAX_LAT);
    localparam logic [3:0]    SKEW_MAX = 4'(SKEW_DEPTH - 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(SKEW_DEPTH - 1);

    typedef enum logic [1:0] {IDLE, CAL_ARM, CAL_RUN, RD_RUN} state_t;

    state_t          state_q;
    logic [3:0]      k_q;                 // edge index since edge 0, saturating
    logic [7:0]      len_q;
    logic [7:0]      popped_q;
    logic [7:0]      pushed_q   [CHANNELS];
    logic [3:0]      lat_q      [CHANNELS];
    logic [PW-1:0]   wr_ptr_q   [CHANNELS];
    logic [PW-1:0]   rd_ptr_q   [CHANNELS];
    logic [CW-1:0]   cnt_q      [CHANNELS];
    logic [DW-1:0]   mem        [CHANNELS][SKEW_DEPTH];
    logic [CHANNELS-1:0] matched_q;
    logic [3:0]      match_lat_q [CHANNELS];

    logic [2*CHANNELS*BIT_WIDTH-1:0] rd_data_q;
    logic            rd_valid_q, rd_last_q, busy_q, cal_valid_q, cal_fail_q;
    logic [4*CHANNELS-1:0] cal_lat_q;

    logic [DW-1:0]   dq_beat  [CHANNELS];
    logic [DW-1:0]   out_beat [CHANNELS];
    logic [3:0]      eff_lat  [CHANNELS];
    logic [3:0]      hit_lat  [CHANNELS];
    logic [CHANNELS-1:0] push, avail, wr_en, rd_en, hit_next;
    logic            pop;
    logic [3:0]      lat_max, lat_min;
    logic            all_hit, skew_ok, cal_done;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_last   = rd_last_q;
    assign bus.busy      = busy_q;
    assign bus.cal_valid = cal_valid_q;
    assign bus.cal_fail  = cal_fail_q;
    assign bus.cal_lat   = cal_lat_q;

    // Per-channel captured beat and the latency a new read would use.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            dq_beat[c] = {bus.dq_in_hi[c*BIT_WIDTH +: BIT_WIDTH],
                          bus.dq_in_lo[c*BIT_WIDTH +: BIT_WIDTH]};
            if (cal_valid_q)
                eff_lat[c] = cal_lat_q[c*4 +: 4];
            else
                eff_lat[c] = (bus.cfg_lat == 4'd0) ? 4'd1 : bus.cfg_lat;
            if (eff_lat[c] > LAT_TOP)
                eff_lat[c] = LAT_TOP;
        end
    end

    // FIFO push/pop: a channel whose FIFO is empty but is capturing this edge
    // passes its beat straight through, so equal latencies cost no extra cycle.
    always_comb begin
        // NOTE: every signal written here gets a value on every path first,
        // otherwise synthesis infers a latch to hold the old value.
        push  = '0;
        avail = '0;
        wr_en = '0;
        rd_en = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            push[c]  = (state_q == RD_RUN) && (k_q >= lat_q[c]) && (pushed_q[c] != len_q);
            avail[c] = (cnt_q[c] != '0) || push[c];
        end
        pop = (state_q == RD_RUN) && (&avail) && (popped_q != len_q);
        for (int c = 0; c < CHANNELS; c++) begin
            out_beat[c] = (cnt_q[c] != '0) ? mem[c][rd_ptr_q[c]] : dq_beat[c];
            rd_en[c]    = pop && (cnt_q[c] != '0);
            wr_en[c]    = push[c] && !(pop && (cnt_q[c] == '0));
        end
    end

    // Calibration search: first matching edge per channel and spread check.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            hit_next[c] = matched_q[c] || (dq_beat[c] == bus.cal_pattern);
            hit_lat[c]  = matched_q[c] ? match_lat_q[c] : k_q;
        end
        lat_max = hit_lat[0];
        lat_min = hit_lat[0];
        for (int c = 1; c < CHANNELS; c++) begin
            if (hit_lat[c] > lat_max) lat_max = hit_lat[c];
            if (hit_lat[c] < lat_min) lat_min = hit_lat[c];
        end
        all_hit  = &hit_next;
        skew_ok  = (lat_max - lat_min) <= SKEW_MAX;
        cal_done = (state_q == CAL_RUN) && (all_hit || (k_q == LAT_TOP));
    end

    // De-skew FIFO storage.
    always_ff @(posedge ram_clk) begin
        // NOTE: storage is deliberately not reset; the reset pointers and
        // counts guarantee no stale entry is ever read.
        for (int c = 0; c < CHANNELS; c++)
            if (wr_en[c])
                mem[c][wr_ptr_q[c]] <= dq_beat[c];
    end

    // Control FSM, counters, FIFO pointers and registered outputs.
    always_ff @(posedge ram_clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state_q     <= IDLE;
            k_q         <= '0;
            len_q       <= '0;
            popped_q    <= '0;
            matched_q   <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            busy_q      <= 1'b0;
            cal_valid_q <= 1'b0;
            cal_fail_q  <= 1'b0;
            cal_lat_q   <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                pushed_q[c]    <= '0;
                lat_q[c]       <= '0;
                wr_ptr_q[c]    <= '0;
                rd_ptr_q[c]    <= '0;
                cnt_q[c]       <= '0;
                match_lat_q[c] <= '0;
            end
        end else begin
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    // The cycle carrying rd_last is already IDLE but still
                    // busy; commands are only taken once busy has dropped.
                    if (busy_q) begin
                        busy_q <= 1'b0;
                    end else if (bus.cal_start) begin
                        state_q    <= CAL_ARM;
                        busy_q     <= 1'b1;
                        cal_fail_q <= 1'b0;
                    end else if (bus.rd_start && (bus.rd_len != 8'd0)) begin
                        state_q  <= RD_RUN;
                        busy_q   <= 1'b1;
                        k_q      <= 4'd1;
                        len_q    <= bus.rd_len;
                        popped_q <= '0;
                        for (int c = 0; c < CHANNELS; c++) begin
                            pushed_q[c] <= '0;
                            lat_q[c]    <= eff_lat[c];
                            wr_ptr_q[c] <= '0;
                            rd_ptr_q[c] <= '0;
                            cnt_q[c]    <= '0;
                        end
                    end
                end
                CAL_ARM: begin
                    if (bus.rd_start) begin
                        state_q   <= CAL_RUN;
                        k_q       <= 4'd1;
                        matched_q <= '0;
                    end
                end
                CAL_RUN: begin
                    matched_q <= hit_next;
                    for (int c = 0; c < CHANNELS; c++)
                        match_lat_q[c] <= hit_lat[c];
                    if (k_q != LAT_TOP)
                        k_q <= k_q + 4'd1;
                    if (cal_done) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        if (all_hit && skew_ok) begin
                            for (int c = 0; c < CHANNELS; c++)
                                cal_lat_q[c*4 +: 4] <= hit_lat[c];
                            cal_valid_q <= 1'b1;
                            cal_fail_q  <= 1'b0;
                        end else begin
                            cal_fail_q <= 1'b1;
                        end
                    end
                end
                RD_RUN: begin
                    if (k_q != LAT_TOP)
                        k_q <= k_q + 4'd1;
                    for (int c = 0; c < CHANNELS; c++) begin
                        if (push[c])
                            pushed_q[c] <= pushed_q[c] + 8'd1;
                        if (wr_en[c])
                            wr_ptr_q[c] <= ptr_inc(wr_ptr_q[c]);
                        if (rd_en[c])
                            rd_ptr_q[c] <= ptr_inc(rd_ptr_q[c]);
                        case ({wr_en[c], rd_en[c]})
                            2'b10:   cnt_q[c] <= cnt_q[c] + CW'(1);
                            2'b01:   cnt_q[c] <= cnt_q[c] - CW'(1);
                            default: cnt_q[c] <= cnt_q[c];
                        endcase
                    end
                    if (pop) begin
                        for (int c = 0; c < CHANNELS; c++)
                            rd_data_q[c*DW +: DW] <= out_beat[c];
                        rd_valid_q <= 1'b1;
                        popped_q   <= popped_q + 8'd1;
                        if (popped_q == len_q - 8'd1) begin
                            rd_last_q <= 1'b1;
                            state_q   <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_psram_rdata_align.sv
// Self-checking bench for psram_rdata_align. A behavioural model tracks the
// calibration result and predicts, per read, which cycles carry which beats
// from the per-channel latencies alone.
module tb_psram_rdata_align;
    localparam int BW         = 16;
    localparam int CH         = 2;
    localparam int MAX_LAT    = 15;
    localparam int SKEW_DEPTH = 4;

    logic ram_clk = 1'b0;
    logic rst_n   = 1'b0;
    always #5 ram_clk = ~ram_clk;

    psram_rdata_align_if #(.BIT_WIDTH(BW), .CHANNELS(CH)) bus ();

    psram_rdata_align #(
        .BIT_WIDTH(BW), .CHANNELS(CH), .MAX_LAT(MAX_LAT), .SKEW_DEPTH(SKEW_DEPTH)
    ) dut (
        .ram_clk(ram_clk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model of the calibration result.
    bit m_cal_valid = 1'b0;
    bit m_cal_fail  = 1'b0;
    int m_cal_lat [CH];
    logic [31:0] beats [CH][256];

    function automatic int eff_lat(input int c, input int cfg);
        int l;
        l = m_cal_valid ? m_cal_lat[c] : ((cfg < 1) ? 1 : cfg);
        return (l > MAX_LAT) ? MAX_LAT : l;
    endfunction

    function automatic logic [4*CH-1:0] model_cal_lat();
        logic [4*CH-1:0] v;
        for (int c = 0; c < CH; c++) v[c*4 +: 4] = 4'(m_cal_lat[c]);
        return v;
    endfunction

    function automatic logic [31:0] nonpat(input logic [31:0] p);
        logic [31:0] v;
        v = $urandom;
        if (v == p) v = ~p;
        return v;
    endfunction

    task automatic drive_beat(input int c, input logic [31:0] v);
        bus.dq_in_hi[c*BW +: BW] = v[31:16];
        bus.dq_in_lo[c*BW +: BW] = v[15:0];
    endtask

    task automatic step();
        @(posedge ram_clk);
        @(negedge ram_clk);
    endtask

    // One read. poke>=0 pulses rd_start+cal_start at that edge (poke==-2
    // picks a random busy edge); rst_at>=0 asserts reset after that beat.
    task automatic run_read(input int len, input int cfg, input int poke_in,
                            input int tail, input bit fixed_data, input int rst_at);
        int lat [CH];
        int lmax, n, seen, poke;
        logic [2*CH*BW-1:0] exp_data;
        bit exp_valid, exp_last, exp_busy;
        lmax = 0;
        for (int c = 0; c < CH; c++) begin
            lat[c] = eff_lat(c, cfg);
            if (lat[c] > lmax) lmax = lat[c];
            for (int i = 0; i < len; i++)
                beats[c][i] = fixed_data ? (32'h1111_0000 + 32'(i)) : $urandom;
        end
        poke = (poke_in == -2) ? int'($urandom_range(1, lmax + len)) : poke_in;
        bus.cfg_lat = 4'(cfg);
        bus.rd_len  = 8'(len);
        seen = 0;
        for (int e = 0; e <= lmax + len - 1 + tail; e++) begin
            for (int c = 0; c < CH; c++)
                if (e >= lat[c] && e - lat[c] < len) drive_beat(c, beats[c][e - lat[c]]);
                else drive_beat(c, $urandom);
            bus.rd_start  = (e == 0) || (e == poke);
            bus.cal_start = (e == poke);
            if (e == poke) bus.rd_len = 8'($urandom_range(1, 255));
            step();
            bus.rd_start  = 1'b0;
            bus.cal_start = 1'b0;
            n = e - lmax;
            exp_valid = (n >= 0) && (n < len);
            exp_last  = (n == len - 1);
            exp_busy  = (e <= lmax + len - 1);
            if (bus.rd_valid !== exp_valid)
                $display("FAIL read_valid edge=%0d: got %b expected %b", e, bus.rd_valid, exp_valid);
            else n_pass++;
            n_checks++;
            if (bus.busy !== exp_busy)
                $display("FAIL read_busy edge=%0d: got %b expected %b", e, bus.busy, exp_busy);
            else n_pass++;
            n_checks++;
            if (bus.rd_last !== exp_last)
                $display("FAIL read_last edge=%0d: got %b expected %b", e, bus.rd_last, exp_last);
            else n_pass++;
            n_checks++;
            if (exp_valid) begin
                for (int c = 0; c < CH; c++) exp_data[c*32 +: 32] = beats[c][n];
                if (bus.rd_data !== exp_data)
                    $display("FAIL read_data beat=%0d: got %h expected %h", n, bus.rd_data, exp_data);
                else n_pass++;
                n_checks++;
            end
            if (bus.rd_valid === 1'b1) seen++;
            if (rst_at >= 0 && seen == rst_at + 1) begin
                rst_n = 1'b0;
                #1;
                m_cal_valid = 1'b0;
                m_cal_fail  = 1'b0;
                for (int c = 0; c < CH; c++) m_cal_lat[c] = 0;
                if ({bus.rd_valid, bus.rd_last, bus.busy, bus.cal_valid, bus.cal_fail} !== 5'b0)
                    $display("FAIL reset_flags: got %b expected 00000",
                             {bus.rd_valid, bus.rd_last, bus.busy, bus.cal_valid, bus.cal_fail});
                else n_pass++;
                n_checks++;
                if (bus.rd_data !== '0 || bus.cal_lat !== '0)
                    $display("FAIL reset_data: got %h/%h expected 0/0", bus.rd_data, bus.cal_lat);
                else n_pass++;
                n_checks++;
                return;
            end
        end
        if (seen != len)
            $display("FAIL read_beat_count: got %0d expected %0d", seen, len);
        else n_pass++;
        n_checks++;
    endtask

    // One calibration. A match edge of 0 means the channel never shows the pattern.
    task automatic run_cal(input int me0, input int me1, input logic [31:0] pat, input bit with_rd);
        int me [CH];
        int eval, mx, mn, gap;
        bit all_m;
        me[0] = me0;
        me[1] = me1;
        all_m = 1'b1;
        mx = 0;
        mn = MAX_LAT + 1;
        for (int c = 0; c < CH; c++) begin
            if (me[c] < 1 || me[c] > MAX_LAT) all_m = 1'b0;
            else begin
                if (me[c] > mx) mx = me[c];
                if (me[c] < mn) mn = me[c];
            end
        end
        eval = all_m ? mx : MAX_LAT;
        bus.cal_pattern = pat;
        bus.cal_start   = 1'b1;
        bus.rd_start    = with_rd;
        bus.rd_len      = 8'($urandom_range(1, 255));
        for (int c = 0; c < CH; c++) drive_beat(c, nonpat(pat));
        step();
        bus.cal_start = 1'b0;
        bus.rd_start  = 1'b0;
        m_cal_fail = 1'b0;
        gap = $urandom_range(0, 2);
        for (int i = 0; i <= gap; i++) begin
            if (bus.busy !== 1'b1 || bus.rd_valid !== 1'b0 || bus.cal_fail !== 1'b0)
                $display("FAIL cal_arm cycle=%0d: got busy=%b valid=%b fail=%b expected 1 0 0",
                         i, bus.busy, bus.rd_valid, bus.cal_fail);
            else n_pass++;
            n_checks++;
            if (i < gap) step();
        end
        bus.rd_start = 1'b1;
        bus.rd_len   = 8'($urandom_range(0, 255));
        step();
        bus.rd_start = 1'b0;
        for (int e = 1; e <= MAX_LAT + 2; e++) begin
            for (int c = 0; c < CH; c++) drive_beat(c, (e == me[c]) ? pat : nonpat(pat));
            step();
            if (e == eval) begin
                if (all_m && (mx - mn) <= SKEW_DEPTH - 1) begin
                    for (int c = 0; c < CH; c++) m_cal_lat[c] = me[c];
                    m_cal_valid = 1'b1;
                    m_cal_fail  = 1'b0;
                end else begin
                    m_cal_fail = 1'b1;
                end
            end
            if (bus.rd_valid !== 1'b0)
                $display("FAIL cal_no_valid edge=%0d: got %b expected 0", e, bus.rd_valid);
            else n_pass++;
            n_checks++;
            if (bus.busy !== (e < eval))
                $display("FAIL cal_busy edge=%0d: got %b expected %b", e, bus.busy, (e < eval));
            else n_pass++;
            n_checks++;
            if (bus.cal_valid !== m_cal_valid || bus.cal_fail !== m_cal_fail)
                $display("FAIL cal_flags edge=%0d: got valid=%b fail=%b expected valid=%b fail=%b",
                         e, bus.cal_valid, bus.cal_fail, m_cal_valid, m_cal_fail);
            else n_pass++;
            n_checks++;
            if (bus.cal_lat !== model_cal_lat())
                $display("FAIL cal_lat edge=%0d: got %h expected %h", e, bus.cal_lat, model_cal_lat());
            else n_pass++;
            n_checks++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge ram_clk);
        if ({bus.rd_valid, bus.rd_last, bus.busy, bus.cal_valid, bus.cal_fail} !== 5'b0)
            $display("FAIL reset_flags: got %b expected 00000",
                     {bus.rd_valid, bus.rd_last, bus.busy, bus.cal_valid, bus.cal_fail});
        else n_pass++;
        n_checks++;
        if (bus.rd_data !== '0 || bus.cal_lat !== '0)
            $display("FAIL reset_data: got %h/%h expected 0/0", bus.rd_data, bus.cal_lat);
        else n_pass++;
        n_checks++;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_cfg_read();
        run_read(4, 3, -1, 3, 1'b1, -1);
        repeat (4) run_read($urandom_range(1, 12), $urandom_range(0, 15), -1, 2, 1'b0, -1);
    endtask

    task automatic test_calibration();
        run_cal(5, 7, 32'hA55A_5AA5, 1'b0);
        run_read(8, 2, -1, 2, 1'b0, -1);
    endtask

    task automatic test_cal_fail();
        run_cal(6, 0, 32'hA55A_5AA5, 1'b0);
        run_read(5, 9, -1, 2, 1'b0, -1);
        run_cal(2, 7, $urandom, 1'b0);
        run_read(3, 1, -1, 2, 1'b0, -1);
    endtask

    task automatic test_cal_random();
        int a, b;
        for (int i = 0; i < 3; i++) begin
            a = $urandom_range(1, 12);
            b = a + int'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) run_cal(b, a, $urandom, 1'b0);
            else run_cal(a, b, $urandom, 1'b0);
            run_read($urandom_range(1, 16), $urandom_range(0, 15), -1, 2, 1'b0, -1);
        end
    endtask

    task automatic test_ignored();
        bus.rd_start = 1'b1;
        bus.rd_len   = 8'd0;
        step();
        bus.rd_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (bus.busy !== 1'b0 || bus.rd_valid !== 1'b0)
                $display("FAIL len_zero cycle=%0d: got busy=%b valid=%b expected 0 0",
                         i, bus.busy, bus.rd_valid);
            else n_pass++;
            n_checks++;
            step();
        end
        run_cal(3, 4, $urandom, 1'b1);
        run_read(6, 4, -1, 2, 1'b0, -1);
        for (int i = 0; i < 3; i++)
            run_read($urandom_range(2, 10), $urandom_range(0, 15), -2, 3, 1'b0, -1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++)
            run_read($urandom_range(1, 8), $urandom_range(0, 15), -1, 1, 1'b0, -1);
    endtask

    task automatic test_reset_mid_burst();
        run_read(8, 2, -1, 0, 1'b0, 2);
        repeat (2) @(negedge ram_clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (bus.rd_valid !== 1'b0 || bus.busy !== 1'b0)
                $display("FAIL post_reset cycle=%0d: got valid=%b busy=%b expected 0 0",
                         i, bus.rd_valid, bus.busy);
            else n_pass++;
            n_checks++;
        end
        run_read(2, 3, -1, 3, 1'b0, -1);
    endtask

    initial begin
        bus.rd_start    = 1'b0;
        bus.rd_len      = 8'd0;
        bus.cfg_lat     = 4'd0;
        bus.cal_start   = 1'b0;
        bus.cal_pattern = '0;
        bus.dq_in_hi    = '0;
        bus.dq_in_lo    = '0;
        for (int c = 0; c < CH; c++) m_cal_lat[c] = 0;
        test_reset();
        test_cfg_read();
        test_calibration();
        test_cal_fail();
        test_cal_random();
        test_ignored();
        test_back_to_back();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end
endmodule
